// File: rtl/bf_program_loader.sv
// bf_program_loader: filters an ASCII Brainfuck source stream, encodes the eight
// commands to 3-bit opcodes and writes them sequentially into program RAM from 0,
// checking bracket balance and reporting the resulting program length.
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse; begins a new load from IDLE, DONE or ERR
//   in_valid/in_data  source byte stream; in_ready high only while loading
//   wr_en/wr_addr/    registered program RAM write port, one opcode per pulse
//   wr_code
//   prog_len          opcodes written so far (final length once done)
//   busy/done/err     LOAD, DONE level, error code (1 ovf, 2 stray ']', 3 open '[')
module bf_program_loader #(
    parameter int          ADDR_W    = 11,
    parameter int          DEPTH     = 2048,
    parameter int          NEST_W    = 8,
    parameter logic [7:0]  TERM_CHAR = 8'h21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_code,
    output logic [ADDR_W:0]   prog_len,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   count, count_nx;
    logic [NEST_W-1:0] depth, depth_nx;
    logic [1:0]        err_nx;
    logic              wr_nx;
    logic              is_cmd;
    logic [2:0]        code;
    logic              xfer;

    assign in_ready = state == LOAD;
    assign busy     = state == LOAD;
    assign done     = state == DONE;
    assign prog_len = count;
    assign xfer     = in_valid & in_ready;

    always_comb begin
        is_cmd = 1'b1;
        code   = 3'b000;
        case (in_data)
            8'h2B:   code = 3'b111;
            8'h2D:   code = 3'b110;
            8'h3E:   code = 3'b101;
            8'h3C:   code = 3'b100;
            8'h5B:   code = 3'b011;
            8'h5D:   code = 3'b010;
            8'h2E:   code = 3'b001;
            8'h2C:   code = 3'b000;
            default: is_cmd = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        depth_nx = depth;
        err_nx   = err;
        wr_nx    = 1'b0;
        case (state)
            LOAD: begin
                if (xfer) begin
                    if (in_data == TERM_CHAR) begin
                        state_nx = (depth == '0) ? DONE : ERR;
                        err_nx   = (depth == '0) ? 2'd0 : 2'd3;
                    end else if (is_cmd) begin
                        // a stray ']' is reported before capacity so the cause is the bracket
                        if (code == 3'b010 && depth == '0) begin
                            state_nx = ERR;
                            err_nx   = 2'd2;
                        end else if (count == (ADDR_W+1)'(DEPTH) ||
                                     (code == 3'b011 && depth == {NEST_W{1'b1}})) begin
                            state_nx = ERR;
                            err_nx   = 2'd1;
                        end else begin
                            wr_nx    = 1'b1;
                            count_nx = count + 1'b1;
                            depth_nx = (code == 3'b011) ? depth + 1'b1 :
                                       (code == 3'b010) ? depth - 1'b1 : depth;
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    state_nx = LOAD;
                    count_nx = '0;
                    depth_nx = '0;
                    err_nx   = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            depth   <= '0;
            err     <= 2'd0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_code <= 3'b000;
        end else begin
            state <= state_nx;
            count <= count_nx;
            depth <= depth_nx;
            err   <= err_nx;
            wr_en <= wr_nx;
            if (wr_nx) begin
                wr_addr <= count[ADDR_W-1:0];
                wr_code <= code;
            end
        end
    end
endmodule
